// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer
// and synchronous flush-to-bubble. Occupancy mirrors the state encoding.
module pipe_skid_stage #(
  parameter int                DATA_W  = 96,
  parameter logic [DATA_W-1:0] BUBBLE  = '0,
  parameter bit                SKID_EN = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [1:0]        Occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              accept;
  logic              rel;

  assign accept    = InValid && InReady;
  assign rel       = OutValid && OutReady;
  assign OutValid  = (state != EMPTY);
  assign OutData   = OutValid ? main_q : BUBBLE;
  assign Occupancy = state;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (Reset || Flush) begin
      state_nxt = EMPTY;
      main_nxt  = BUBBLE;
      skid_nxt  = BUBBLE;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            main_nxt  = InData;
          end
        end
        ONE: begin
          if (accept && rel) begin
            main_nxt = InData;
          end else if (accept && SKID_EN) begin
            state_nxt = TWO;
            skid_nxt  = InData;
          end else if (rel) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (rel) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = BUBBLE;
          skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    state  <= state_nxt;
    main_q <= main_nxt;
    skid_q <= skid_nxt;
  end

  generate
    if (SKID_EN) begin : g_skid
      // Ready flop follows the next state; the skid entry covers its one-cycle lag.
      logic in_ready_q;
      always_ff @(posedge Clk) begin
        in_ready_q <= (state_nxt != TWO);
      end
      assign InReady = in_ready_q && !Reset;
    end else begin : g_single
      assign InReady = !Reset && (!OutValid || OutReady);
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: table-driven vectors on the skid variant,
// hand-written sequences on the single-entry variant.
module tb_pipe_skid_stage;

  localparam int          W   = 16;
  localparam logic [W-1:0] BUB = 16'hB0B0;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // skid instance signals
  logic         rst_a, fl_a, iv_a, ir_a, ov_a, ordy_a;
  logic [W-1:0] id_a, od_a;
  logic [1:0]   occ_a;
  // single-entry instance signals
  logic         rst_b, fl_b, iv_b, ir_b, ov_b, ordy_b;
  logic [W-1:0] id_b, od_b;
  logic [1:0]   occ_b;

  pipe_skid_stage #(.DATA_W(W), .BUBBLE(BUB), .SKID_EN(1'b1)) u_skid (
    .Clk(Clk), .Reset(rst_a), .Flush(fl_a), .InValid(iv_a), .InReady(ir_a),
    .InData(id_a), .OutValid(ov_a), .OutReady(ordy_a), .OutData(od_a), .Occupancy(occ_a)
  );

  pipe_skid_stage #(.DATA_W(W), .BUBBLE(BUB), .SKID_EN(1'b0)) u_single (
    .Clk(Clk), .Reset(rst_b), .Flush(fl_b), .InValid(iv_b), .InReady(ir_b),
    .InData(id_b), .OutValid(ov_b), .OutReady(ordy_b), .OutData(od_b), .Occupancy(occ_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         rst;
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         eov;
    logic [W-1:0] eod;
    logic         eir;
    logic [1:0]   eocc;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [W-1:0] d, logic ordy,
                              logic eov, logic [W-1:0] eod, logic eir, logic [1:0] eocc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eir = eir; v.eocc = eocc;
    return v;
  endfunction

  // advance one edge, then move off it before driving
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; fl_a = 1'b0; iv_a = 1'b0; id_a = '0; ordy_a = 1'b0;
    rst_b = 1'b1; fl_b = 1'b0; iv_b = 1'b0; id_b = '0; ordy_b = 1'b0;

    // Each row: inputs for the cycle, expected outputs seen before its closing edge.
    //              rst fl iv data      ordy  ov  od        ir  occ
    tbl[0]  = mk(1, 0, 0, 16'h0000, 0,   0, BUB,      0, 2'd0);
    tbl[1]  = mk(0, 0, 1, 16'h0001, 1,   0, BUB,      1, 2'd0);
    tbl[2]  = mk(0, 0, 1, 16'h0002, 1,   1, 16'h0001, 1, 2'd1);
    tbl[3]  = mk(0, 0, 1, 16'h0003, 1,   1, 16'h0002, 1, 2'd1);
    tbl[4]  = mk(0, 0, 1, 16'h0004, 1,   1, 16'h0003, 1, 2'd1);
    tbl[5]  = mk(0, 0, 1, 16'h0005, 1,   1, 16'h0004, 1, 2'd1);
    tbl[6]  = mk(0, 0, 1, 16'h0006, 1,   1, 16'h0005, 1, 2'd1);
    tbl[7]  = mk(0, 0, 1, 16'h0007, 1,   1, 16'h0006, 1, 2'd1);
    tbl[8]  = mk(0, 0, 1, 16'h0008, 1,   1, 16'h0007, 1, 2'd1);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 1,   1, 16'h0008, 1, 2'd1);
    // backpressure fill/drain
    tbl[10] = mk(0, 0, 1, 16'h000A, 0,   0, BUB,      1, 2'd0);
    tbl[11] = mk(0, 0, 1, 16'h000B, 0,   1, 16'h000A, 1, 2'd1);
    tbl[12] = mk(0, 0, 1, 16'h000C, 0,   1, 16'h000A, 0, 2'd2);
    tbl[13] = mk(0, 0, 1, 16'h000C, 1,   1, 16'h000A, 0, 2'd2);
    tbl[14] = mk(0, 0, 1, 16'h000C, 1,   1, 16'h000B, 1, 2'd1);
    tbl[15] = mk(0, 0, 0, 16'h0000, 1,   1, 16'h000C, 1, 2'd1);
    tbl[16] = mk(0, 0, 0, 16'h0000, 1,   0, BUB,      1, 2'd0);
    // flush with simultaneous accept
    tbl[17] = mk(0, 0, 1, 16'h0011, 0,   0, BUB,      1, 2'd0);
    tbl[18] = mk(0, 0, 1, 16'h0022, 0,   1, 16'h0011, 1, 2'd1);
    tbl[19] = mk(0, 0, 0, 16'h0000, 1,   1, 16'h0011, 0, 2'd2);
    tbl[20] = mk(0, 1, 1, 16'h0033, 0,   1, 16'h0022, 1, 2'd1);
    tbl[21] = mk(0, 0, 0, 16'h0000, 1,   0, BUB,      1, 2'd0);
    // accept and release together in ONE
    tbl[22] = mk(0, 0, 1, 16'h0005, 0,   0, BUB,      1, 2'd0);
    tbl[23] = mk(0, 0, 1, 16'h0006, 1,   1, 16'h0005, 1, 2'd1);
    tbl[24] = mk(0, 0, 0, 16'h0000, 1,   1, 16'h0006, 1, 2'd1);
    // reset mid-stream
    tbl[25] = mk(0, 0, 1, 16'h0009, 0,   0, BUB,      1, 2'd0);
    tbl[26] = mk(0, 0, 1, 16'h000A, 0,   1, 16'h0009, 1, 2'd1);
    tbl[27] = mk(1, 0, 0, 16'h0000, 1,   1, 16'h0009, 0, 2'd2);
    tbl[28] = mk(1, 0, 0, 16'h0000, 1,   0, BUB,      0, 2'd0);
    tbl[29] = mk(0, 0, 0, 16'h0000, 1,   0, BUB,      1, 2'd0);

    tick();  // first reset edge for both instances

    for (int i = 0; i < NV; i++) begin
      rst_a = tbl[i].rst; fl_a = tbl[i].fl; iv_a = tbl[i].iv;
      id_a = tbl[i].d; ordy_a = tbl[i].ordy;
      #1;
      chk($sformatf("skid[%0d].OutValid", i),  32'(ov_a),  32'(tbl[i].eov));
      chk($sformatf("skid[%0d].OutData", i),   32'(od_a),  32'(tbl[i].eod));
      chk($sformatf("skid[%0d].InReady", i),   32'(ir_a),  32'(tbl[i].eir));
      chk($sformatf("skid[%0d].Occupancy", i), 32'(occ_a), 32'(tbl[i].eocc));
      tick();
    end

    // ---- single-entry variant ----
    rst_b = 1'b0;
    #1;
    chk("single.reset_OutValid", 32'(ov_b), 32'd0);
    chk("single.reset_OutData", 32'(od_b), 32'(BUB));
    chk("single.reset_InReady", 32'(ir_b), 32'd1);

    // streaming 1..4 then drain
    ordy_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      iv_b = (k <= 4);
      id_b = 16'(k);
      #1;
      chk($sformatf("single.stream%0d_InReady", k), 32'(ir_b), 32'd1);
      if (k > 1) chk($sformatf("single.stream%0d_OutData", k), 32'(od_b), 32'(k - 1));
      tick();
    end
    iv_b = 1'b0;
    #1;
    chk("single.drained_OutValid", 32'(ov_b), 32'd0);

    // stall with 0x7 held
    iv_b = 1'b1; id_b = 16'h0007; ordy_b = 1'b0;
    tick();
    iv_b = 1'b0;
    #1;
    chk("single.stall_InReady", 32'(ir_b), 32'd0);
    chk("single.stall_OutData", 32'(od_b), 32'h7);
    chk("single.stall_Occupancy", 32'(occ_b), 32'd1);
    ordy_b = 1'b1;
    #1;
    chk("single.comb_InReady", 32'(ir_b), 32'd1);
    iv_b = 1'b1; id_b = 16'h0008;
    tick();
    iv_b = 1'b0; ordy_b = 1'b0;
    #1;
    chk("single.replace_OutData", 32'(od_b), 32'h8);
    chk("single.replace_Occupancy", 32'(occ_b), 32'd1);

    // held data stays stable while upstream is blocked
    iv_b = 1'b1; id_b = 16'h0009;
    tick();
    chk("single.hold_OutData", 32'(od_b), 32'h8);
    chk("single.hold_InReady", 32'(ir_b), 32'd0);

    // flush clears the held entry
    fl_b = 1'b1;
    tick();
    fl_b = 1'b0; iv_b = 1'b0;
    #1;
    chk("single.flush_OutValid", 32'(ov_b), 32'd0);
    chk("single.flush_OutData", 32'(od_b), 32'(BUB));
    chk("single.flush_InReady", 32'(ir_b), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
